// File: rtl/edge_corner_finder_pkg.sv
// Shared widths, state encoding and corner-metric helpers for the edge-map corner finder.
package edge_corner_finder_pkg;

  localparam int ADDR_W     = 19;
  localparam int X_W        = 10;
  localparam int Y_W        = 9;
  localparam int ROW_STRIDE = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } point_t;

  // s = x + y, ranks pixels along the TL..BR diagonal
  function automatic logic [10:0] sum_of(input point_t p);
    return {1'b0, p.x} + {2'b00, p.y};
  endfunction

  // d = x - y, ranks pixels along the BL..TR diagonal
  function automatic logic signed [10:0] diff_of(input point_t p);
    return $signed({1'b0, p.x}) - $signed({2'b00, p.y});
  endfunction

endpackage

// File: rtl/edge_corner_finder_corner_tracker.sv
// Keeps the four extreme edge pixels seen so far; strict compares keep the earliest pixel on ties.
module corner_tracker
  import edge_corner_finder_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           sample_valid,
  input  logic           edge_bit,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic           valid,
  output point_t         tl,
  output point_t         tr,
  output point_t         bl,
  output point_t         br
);

  logic   valid_q, valid_d;
  point_t tl_q, tl_d, tr_q, tr_d, bl_q, bl_d, br_q, br_d;
  point_t pix;

  always_comb begin
    valid_d = valid_q;
    tl_d    = tl_q;
    tr_d    = tr_q;
    bl_d    = bl_q;
    br_d    = br_q;
    pix     = '{x: x, y: y};
    if (clear) begin
      valid_d = 1'b0;
      tl_d    = '0;
      tr_d    = '0;
      bl_d    = '0;
      br_d    = '0;
    end else if (sample_valid && edge_bit) begin
      if (!valid_q) begin
        valid_d = 1'b1;
        tl_d    = pix;
        tr_d    = pix;
        bl_d    = pix;
        br_d    = pix;
      end else begin
        if (sum_of(pix) < sum_of(tl_q))   tl_d = pix;
        if (sum_of(pix) > sum_of(br_q))   br_d = pix;
        if (diff_of(pix) > diff_of(tr_q)) tr_d = pix;
        if (diff_of(pix) < diff_of(bl_q)) bl_d = pix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      tl_q    <= '0;
      tr_q    <= '0;
      bl_q    <= '0;
      br_q    <= '0;
    end else begin
      valid_q <= valid_d;
      tl_q    <= tl_d;
      tr_q    <= tr_d;
      bl_q    <= bl_d;
      br_q    <= br_d;
    end
  end

  assign valid = valid_q;
  assign tl    = tl_q;
  assign tr    = tr_q;
  assign bl    = bl_q;
  assign br    = br_q;

endmodule

// File: rtl/edge_corner_finder.sv
// Scans the 1-bit edge map row-major and reports the four document corners with a start/done handshake.
// Handshake: start is honoured only in IDLE; done pulses for one cycle while the corner outputs are valid.
module edge_corner_finder
  import edge_corner_finder_pkg::*;
#(
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic [ADDR_W-1:0] read_addr,
  input  logic              read_data,
  output logic              found,
  output logic [X_W-1:0]    tl_x,
  output logic [X_W-1:0]    tr_x,
  output logic [X_W-1:0]    bl_x,
  output logic [X_W-1:0]    br_x,
  output logic [Y_W-1:0]    tl_y,
  output logic [Y_W-1:0]    tr_y,
  output logic [Y_W-1:0]    bl_y,
  output logic [Y_W-1:0]    br_y,
  output state_e            state_dbg
);

  localparam int DRAIN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_e               state_q, state_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 clear;
  logic                 last_pix, fin;

  logic [READ_LATENCY-1:0] pipe_v_q, pipe_v_d;
  point_t                  pipe_pt_q [READ_LATENCY];
  point_t                  pipe_pt_d [READ_LATENCY];

  logic   trk_valid, out_found_q, out_found_d;
  point_t trk_tl, trk_tr, trk_bl, trk_br;
  point_t out_tl_q, out_tr_q, out_bl_q, out_br_q;
  point_t out_tl_d, out_tr_d, out_bl_d, out_br_d;
  point_t show_tl, show_tr, show_bl, show_br;

  assign last_pix = (x_q == X_W'(IMG_WIDTH - 1)) && (y_q == Y_W'(IMG_HEIGHT - 1));
  assign fin      = (state_q == ST_FINISH);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    drain_d = drain_q;
    clear   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        x_d = '0;
        y_d = '0;
        if (start) begin
          state_d = ST_SCAN;
          clear   = 1'b1;
        end
      end
      ST_SCAN: begin
        if (last_pix) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else if (x_q == X_W'(IMG_WIDTH - 1)) begin
          x_d = '0;
          y_d = y_q + Y_W'(1);
        end else begin
          x_d = x_q + X_W'(1);
        end
      end
      ST_DRAIN: begin
        // address holds here while the last reads return
        if (drain_q == DRAIN_W'(READ_LATENCY - 1)) state_d = ST_FINISH;
        else drain_d = drain_q + DRAIN_W'(1);
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        x_d     = '0;
        y_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Coordinates ride alongside the memory pipeline so each read_data bit meets its own pixel.
  always_comb begin
    pipe_v_d[0]  = (state_q == ST_SCAN);
    pipe_pt_d[0] = '{x: x_q, y: y_q};
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_v_d[i]  = pipe_v_q[i-1];
      pipe_pt_d[i] = pipe_pt_q[i-1];
    end
  end

  always_comb begin
    out_found_d = out_found_q;
    out_tl_d    = out_tl_q;
    out_tr_d    = out_tr_q;
    out_bl_d    = out_bl_q;
    out_br_d    = out_br_q;
    if (fin) begin
      out_found_d = trk_valid;
      out_tl_d    = trk_tl;
      out_tr_d    = trk_tr;
      out_bl_d    = trk_bl;
      out_br_d    = trk_br;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      drain_q     <= '0;
      pipe_v_q    <= '0;
      out_found_q <= 1'b0;
      out_tl_q    <= '0;
      out_tr_q    <= '0;
      out_bl_q    <= '0;
      out_br_q    <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      drain_q     <= drain_d;
      pipe_v_q    <= pipe_v_d;
      out_found_q <= out_found_d;
      out_tl_q    <= out_tl_d;
      out_tr_q    <= out_tr_d;
      out_bl_q    <= out_bl_d;
      out_br_q    <= out_br_d;
    end
    pipe_pt_q <= pipe_pt_d;
  end

  corner_tracker u_tracker (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .sample_valid (pipe_v_q[READ_LATENCY-1]),
    .edge_bit     (read_data),
    .x            (pipe_pt_q[READ_LATENCY-1].x),
    .y            (pipe_pt_q[READ_LATENCY-1].y),
    .valid        (trk_valid),
    .tl           (trk_tl),
    .tr           (trk_tr),
    .bl           (trk_bl),
    .br           (trk_br)
  );

  // During FINISH the tracker is already final, so it is shown directly while being latched.
  assign show_tl = fin ? trk_tl : out_tl_q;
  assign show_tr = fin ? trk_tr : out_tr_q;
  assign show_bl = fin ? trk_bl : out_bl_q;
  assign show_br = fin ? trk_br : out_br_q;

  assign done      = fin;
  assign found     = fin ? trk_valid : out_found_q;
  assign read_addr = {y_q, x_q};
  assign tl_x      = show_tl.x;
  assign tl_y      = show_tl.y;
  assign tr_x      = show_tr.x;
  assign tr_y      = show_tr.y;
  assign bl_x      = show_bl.x;
  assign bl_y      = show_bl.y;
  assign br_x      = show_br.x;
  assign br_y      = show_br.y;
  assign state_dbg = state_q;

endmodule
